// File: rtl/mbus_power_seq_pkg.sv
// Shared types and constants for the MBus member-node layer power sequencer.
`timescale 1ns/1ps
package mbus_power_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASLEEP   = 3'd0,
        ST_PWR_UP   = 3'd1,
        ST_REL_RST  = 3'd2,
        ST_AWAKE    = 3'd3,
        ST_HOLD_ISO = 3'd4,
        ST_CLR      = 3'd5
    } pseq_state_e;

    // Isolation encoding shared with the rest of the MBus library.
    localparam logic IO_HOLD    = 1'b1;
    localparam logic IO_RELEASE = 1'b0;

    function automatic int clamp_cyc(input int cyc);
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/mbus_power_seq_if.sv
// Bus-side and power-control signals between the sequencer and its neighbours.
`timescale 1ns/1ps
interface mbus_power_seq_if;

    logic BUS_BUSYn;
    logic SLEEP_REQ;
    logic WAKEUP_REQ;
    logic MBC_SLEEP;
    logic MBC_SLEEP_B;
    logic MBC_ISOLATE;
    logic MBC_ISOLATE_B;
    logic MBC_RESET;
    logic MBC_RESET_B;
    logic SC_CLR_BUSY;

    modport slave (
        input  BUS_BUSYn, SLEEP_REQ, WAKEUP_REQ,
        output MBC_SLEEP, MBC_SLEEP_B, MBC_ISOLATE, MBC_ISOLATE_B,
               MBC_RESET, MBC_RESET_B, SC_CLR_BUSY
    );

    modport master (
        output BUS_BUSYn, SLEEP_REQ, WAKEUP_REQ,
        input  MBC_SLEEP, MBC_SLEEP_B, MBC_ISOLATE, MBC_ISOLATE_B,
               MBC_RESET, MBC_RESET_B, SC_CLR_BUSY
    );

endinterface

// File: rtl/mbus_power_seq_sync2.sv
// Two-flop synchronizer for an asynchronous level input, clears to 0 on reset.
`timescale 1ns/1ps
module mbus_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mbus_power_seq.sv
// Orders power un-gate, isolation release and reset release of the bus
// controller domain on wake, and reverses the order on sleep.
`timescale 1ns/1ps
module mbus_power_seq
    import mbus_power_seq_pkg::*;
#(
    parameter int PWR_SETTLE_CYC = 2,
    parameter int ISO_SETTLE_CYC = 1,
    parameter int CNT_W          = 4
) (
    input  logic           MBUS_CLK,
    input  logic           RESETn,
    mbus_power_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(clamp_cyc(PWR_SETTLE_CYC) - 1);
    localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(clamp_cyc(ISO_SETTLE_CYC) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pseq_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sleep_pend_q;
    logic             sleep_q, sleep_b_q;
    logic             iso_q, iso_b_q;
    logic             rst_q, rst_b_q;
    logic             clr_q;
    logic             wake_s;

    mbus_sync2 u_wake_sync (
        .clk_i   (MBUS_CLK),
        .rst_n_i (RESETn),
        .d_i     (bus.WAKEUP_REQ),
        .q_o     (wake_s)
    );

    // Sequencer FSM; each _b flop is written alongside its true output.
    always_ff @(posedge MBUS_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= ST_ASLEEP;
            cnt_q        <= '0;
            sleep_pend_q <= 1'b0;
            sleep_q      <= 1'b1;
            sleep_b_q    <= 1'b0;
            iso_q        <= IO_HOLD;
            iso_b_q      <= ~IO_HOLD;
            rst_q        <= 1'b1;
            rst_b_q      <= 1'b0;
            clr_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_ASLEEP: begin
                    if (!bus.BUS_BUSYn || wake_s) begin
                        sleep_q   <= 1'b0;
                        sleep_b_q <= 1'b1;
                        cnt_q     <= PWR_LOAD;
                        state_q   <= ST_PWR_UP;
                    end
                end
                ST_PWR_UP: begin
                    if (bus.SLEEP_REQ) sleep_pend_q <= 1'b1;
                    if (cnt_q == '0) begin
                        iso_q   <= IO_RELEASE;
                        iso_b_q <= ~IO_RELEASE;
                        cnt_q   <= ISO_LOAD;
                        state_q <= ST_REL_RST;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_REL_RST: begin
                    if (bus.SLEEP_REQ) sleep_pend_q <= 1'b1;
                    if (cnt_q == '0) begin
                        rst_q   <= 1'b0;
                        rst_b_q <= 1'b1;
                        state_q <= ST_AWAKE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_AWAKE: begin
                    // Sleep wins over a concurrent wake; ASLEEP re-powers if wake persists.
                    if (bus.SLEEP_REQ || sleep_pend_q) begin
                        rst_q        <= 1'b1;
                        rst_b_q      <= 1'b0;
                        iso_q        <= IO_HOLD;
                        iso_b_q      <= ~IO_HOLD;
                        cnt_q        <= ISO_LOAD;
                        sleep_pend_q <= 1'b0;
                        state_q      <= ST_HOLD_ISO;
                    end
                end
                ST_HOLD_ISO: begin
                    if (cnt_q == '0) begin
                        sleep_q   <= 1'b1;
                        sleep_b_q <= 1'b0;
                        clr_q     <= 1'b1;
                        state_q   <= ST_CLR;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_CLR: begin
                    clr_q   <= 1'b0;
                    state_q <= ST_ASLEEP;
                end
                default: begin
                    state_q      <= ST_ASLEEP;
                    cnt_q        <= '0;
                    sleep_pend_q <= 1'b0;
                    sleep_q      <= 1'b1;
                    sleep_b_q    <= 1'b0;
                    iso_q        <= IO_HOLD;
                    iso_b_q      <= ~IO_HOLD;
                    rst_q        <= 1'b1;
                    rst_b_q      <= 1'b0;
                    clr_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MBC_SLEEP     = sleep_q;
    assign bus.MBC_SLEEP_B   = sleep_b_q;
    assign bus.MBC_ISOLATE   = iso_q;
    assign bus.MBC_ISOLATE_B = iso_b_q;
    assign bus.MBC_RESET     = rst_q;
    assign bus.MBC_RESET_B   = rst_b_q;
    assign bus.SC_CLR_BUSY   = clr_q;

endmodule

// File: tb/tb_mbus_power_seq.sv
// Directed bench for mbus_power_seq with default settle parameters.
`timescale 1ns/1ps
module tb_mbus_power_seq;

    // Output vector order: {SLEEP, ISOLATE, RESET, CLR_BUSY, SLEEP_B, ISOLATE_B, RESET_B}
    localparam logic [6:0] V_ASLEEP  = 7'b1110000;
    localparam logic [6:0] V_PWRD    = 7'b0110100;
    localparam logic [6:0] V_ISOREL  = 7'b0010110;
    localparam logic [6:0] V_AWAKE   = 7'b0000111;
    localparam logic [6:0] V_HOLDISO = 7'b0110100;
    localparam logic [6:0] V_CLR     = 7'b1111000;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mbus_power_seq_if bus ();

    mbus_power_seq dut (
        .MBUS_CLK (clk),
        .RESETn   (rst_n),
        .bus      (bus)
    );

    wire [6:0] obs = {bus.MBC_SLEEP, bus.MBC_ISOLATE, bus.MBC_RESET, bus.SC_CLR_BUSY,
                      bus.MBC_SLEEP_B, bus.MBC_ISOLATE_B, bus.MBC_RESET_B};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.BUS_BUSYn  = 1'b1;
        bus.SLEEP_REQ  = 1'b0;
        bus.WAKEUP_REQ = 1'b0;
        #12;
        n_cmp++;
        if (obs !== V_ASLEEP) begin
            n_bad++;
            $display("FAIL reset_values: got %b want %b", obs, V_ASLEEP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (obs !== V_ASLEEP) begin
                n_bad++;
                $display("FAIL idle_asleep edge%0d: got %b want %b", i, obs, V_ASLEEP);
            end
        end
    endtask

    task automatic test_power_up();
        logic [6:0] exp_seq [4];
        exp_seq = '{V_PWRD, V_PWRD, V_ISOREL, V_AWAKE};
        bus.BUS_BUSYn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.BUS_BUSYn = 1'b1;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL power_up N+%0d: got %b want %b", i, obs, exp_seq[i]);
            end
        end
        step();
        n_cmp++;
        if (obs !== V_AWAKE) begin
            n_bad++;
            $display("FAIL stay_awake: got %b want %b", obs, V_AWAKE);
        end
    endtask

    task automatic test_power_down();
        logic [6:0] exp_seq [4];
        exp_seq = '{V_HOLDISO, V_CLR, V_ASLEEP, V_ASLEEP};
        bus.SLEEP_REQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.SLEEP_REQ = 1'b0;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL power_down M+%0d: got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_sleep_pend();
        logic [6:0] exp_seq [8];
        exp_seq = '{V_PWRD, V_PWRD, V_ISOREL, V_AWAKE, V_HOLDISO, V_CLR, V_ASLEEP, V_ASLEEP};
        bus.BUS_BUSYn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            bus.BUS_BUSYn = 1'b1;
            bus.SLEEP_REQ = (i == 0);
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL sleep_pend N+%0d: got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wake_through_sleep();
        logic [6:0] exp_up [6];
        logic [6:0] exp_dn [8];
        exp_up = '{V_ASLEEP, V_ASLEEP, V_PWRD, V_PWRD, V_ISOREL, V_AWAKE};
        exp_dn = '{V_HOLDISO, V_CLR, V_ASLEEP, V_PWRD, V_PWRD, V_ISOREL, V_AWAKE, V_AWAKE};
        bus.WAKEUP_REQ = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_up[i]) begin
                n_bad++;
                $display("FAIL wake_sync_up %0d: got %b want %b", i, obs, exp_up[i]);
            end
        end
        bus.SLEEP_REQ = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            bus.SLEEP_REQ = 1'b0;
            if (i == 3) bus.WAKEUP_REQ = 1'b0;
            n_cmp++;
            if (obs !== exp_dn[i]) begin
                n_bad++;
                $display("FAIL wake_vs_sleep M+%0d: got %b want %b", i, obs, exp_dn[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] exp_seq [6];
        exp_seq = '{V_HOLDISO, V_CLR, V_ASLEEP, V_PWRD, V_PWRD, V_ISOREL};
        bus.SLEEP_REQ = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.SLEEP_REQ = 1'b0;
            bus.BUS_BUSYn = (i == 2) ? 1'b0 : 1'b1;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL reach_rel_rst %0d: got %b want %b", i, obs, exp_seq[i]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== V_ASLEEP) begin
            n_bad++;
            $display("FAIL async_reset: got %b want %b", obs, V_ASLEEP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (obs !== V_ASLEEP) begin
                n_bad++;
                $display("FAIL post_reset %0d: got %b want %b", i, obs, V_ASLEEP);
            end
        end
        bus.BUS_BUSYn = 1'b0;
        step();
        bus.BUS_BUSYn = 1'b1;
        n_cmp++;
        if (obs !== V_PWRD) begin
            n_bad++;
            $display("FAIL recover_wake: got %b want %b", obs, V_PWRD);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_power_up();
        test_power_down();
        test_sleep_pend();
        test_wake_through_sleep();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
